// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: streams matrix A then B over valid/ready, packs them and strobes load_n
module matrix_stream_loader #(
    parameter int A_ROW = 2,
    parameter int A_COL = 2,
    parameter int B_ROW = 2,
    parameter int B_COL = 2,
    parameter int A_LEN = A_ROW*A_COL*8,
    parameter int B_LEN = B_ROW*B_COL*8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [A_LEN-1:0] a,
    output logic [B_LEN-1:0] b,
    output logic             load_n,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int A_N = A_ROW*A_COL;
    localparam int B_N = B_ROW*B_COL;
    localparam int MAX_N = (A_N > B_N) ? A_N : B_N;
    localparam int CW = $clog2(MAX_N + 1);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, PRESENT, DONE} state_t;
    state_t           state_q, state_d;
    logic [A_LEN-1:0] a_q, a_d;
    logic [B_LEN-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             in_ready_q, in_ready_d;
    logic             load_n_q, load_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             xfer;
    assign xfer     = in_valid && in_ready_q;
    assign in_ready = in_ready_q;
    assign a        = a_q;
    assign b        = b_q;
    assign load_n   = load_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    // next-state, packing and error tracking; outputs are decoded from the next state so they register with it
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (A_COL != B_ROW) begin
                        err_d = 1'b1;
                    end else begin
                        a_d     = '0;
                        b_d     = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = LOAD_A;
                    end
                end
            end
            LOAD_A: begin
                if (xfer) begin
                    a_d[8*(A_N-1-int'(cnt_q)) +: 8] = in_data;
                    err_d = err_q | in_last;
                    if (cnt_q == CW'(A_N-1)) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_B: begin
                if (xfer) begin
                    b_d[8*(B_N-1-int'(cnt_q)) +: 8] = in_data;
                    if (cnt_q == CW'(B_N-1)) begin
                        err_d   = err_q | ~in_last;
                        cnt_d   = '0;
                        state_d = PRESENT;
                    end else begin
                        err_d = err_q | in_last;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PRESENT: state_d = DONE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
        load_n_d   = state_d != PRESENT;
        busy_d     = (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == PRESENT);
        done_d     = state_d == DONE;
    end
    // state and registered outputs; reset drops any partial load at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            load_n_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            load_n_q   <= load_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader: directed and randomized loads checked against a byte-list model
module tb_matrix_stream_loader;
    typedef logic [7:0] bytes_t [8];
    typedef logic       bits_t  [8];
    typedef int         ints_t  [8];
    logic        clk = 0, rst = 0, start = 0, start2 = 0, in_valid = 0, in_last = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, load_n, busy, done, err;
    logic [31:0] a, b;
    logic        in_ready2, load_n2, busy2, done2, err2;
    logic [47:0] a2;
    logic [31:0] b2;
    logic        start_in_b = 0;
    int          errors = 0, checks = 0;
    bytes_t      d;
    bits_t       l;
    ints_t       st;

    matrix_stream_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .a(a), .b(b), .load_n(load_n),
        .busy(busy), .done(done), .err(err)
    );

    matrix_stream_loader #(.A_ROW(2), .A_COL(3), .B_ROW(2), .B_COL(2)) dut_mm (
        .clk(clk), .rst(rst), .start(start2), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready2), .a(a2), .b(b2), .load_n(load_n2),
        .busy(busy2), .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
        chk("start_busy", busy, 1);
        chk("start_ready", in_ready, 1);
        chk("start_err_clear", err, 0);
        chk("start_a_clear", a, 0);
        chk("start_done_clear", done, 0);
    endtask

    function automatic logic [31:0] pack(input bytes_t v, input int off);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) r = (r << 8) | 32'(v[off+i]);
        return r;
    endfunction

    function automatic logic model_err(input bits_t f);
        logic e = !f[7];
        for (int i = 0; i < 7; i++) e |= f[i];
        return e;
    endfunction

    task automatic send(input bytes_t v, input bits_t f, input ints_t s);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < s[i]; k++) begin
                in_valid = 0;
                tick();
                chk("stall_load_n", load_n, 1);
                chk("stall_ready", in_ready, 1);
            end
            in_valid = 1;
            in_data  = v[i];
            in_last  = f[i];
            start    = (i >= 4) ? start_in_b : 1'b0;
            chk("xfer_ready", in_ready, 1);
            chk("xfer_load_n", load_n, 1);
            tick();
        end
        in_valid = 0;
        in_last  = 0;
        start    = 0;
    endtask

    task automatic verify(input bytes_t v, input bits_t f);
        chk("present_load_n", load_n, 0);
        chk("present_ready", in_ready, 0);
        chk("present_busy", busy, 1);
        chk("present_a", a, pack(v, 0));
        chk("present_b", b, pack(v, 4));
        tick();
        chk("done_load_n", load_n, 1);
        chk("done_flag", done, 1);
        chk("done_busy", busy, 0);
        chk("done_err", err, model_err(f));
        chk("done_a", a, pack(v, 0));
        chk("done_b", b, pack(v, 4));
    endtask

    initial begin
        tick();
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_load_n", load_n, 1);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1;
        tick();
        chk("idle_ready", in_ready, 0);

        d  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        l  = '{default: 1'b0};
        l[7] = 1;
        st = '{default: 0};
        do_start();
        send(d, l, st);
        verify(d, l);
        chk("t1_a_const", a, 32'h01020304);
        chk("t1_b_const", b, 32'h05060708);

        st[2] = 3;
        st[6] = 3;
        do_start();
        send(d, l, st);
        verify(d, l);

        st = '{default: 0};
        l[2] = 1;
        do_start();
        send(d, l, st);
        verify(d, l);
        chk("t3_err", err, 1);
        chk("t3_a_const", a, 32'h01020304);
        l[2] = 0;
        for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
        do_start();
        send(d, l, st);
        verify(d, l);

        d = '{8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
        do_start();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            in_data  = d[i];
            tick();
        end
        in_valid = 0;
        #2 rst = 0;
        #1;
        chk("mid_rst_a", a, 0);
        chk("mid_rst_b", b, 0);
        chk("mid_rst_load_n", load_n, 1);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        chk("mid_rst_hold_load_n", load_n, 1);
        rst = 1;
        tick();
        chk("post_rst_idle_busy", busy, 0);
        do_start();
        send(d, l, st);
        verify(d, l);
        chk("t4_a_const", a, 32'h090A0B0C);
        chk("t4_b_const", b, 32'h0D0E0F10);

        chk("mm_err_before", err2, 0);
        start2 = 1;
        tick();
        start2 = 0;
        chk("mm_err", err2, 1);
        chk("mm_ready", in_ready2, 0);
        chk("mm_load_n", load_n2, 1);
        chk("mm_busy", busy2, 0);
        chk("mm_done", done2, 0);
        repeat (3) tick();
        chk("mm_stay_ready", in_ready2, 0);
        chk("mm_stay_busy", busy2, 0);
        chk("mm_a", a2, 0);
        chk("mm_b", b2, 0);

        d = '{8'hFF, 8'h80, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 4; i < 8; i++) d[i] = 8'($urandom);
        start_in_b = 1;
        do_start();
        send(d, l, st);
        start_in_b = 0;
        verify(d, l);
        chk("t6_a_const", a, 32'hFF800001);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 8; i++) begin
                d[i]  = 8'($urandom);
                l[i]  = ($urandom_range(0, 7) == 0);
                st[i] = $urandom_range(0, 2);
            end
            l[7] = ($urandom_range(0, 3) != 0);
            do_start();
            send(d, l, st);
            verify(d, l);
            repeat (3) tick();
            chk("hold_a", a, pack(d, 0));
            chk("hold_b", b, pack(d, 4));
            chk("hold_done", done, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
